// File: rtl/lane_result_streamer_pkg.sv
// Shared constants and types for the lane result streamer: frame geometry
// defaults, FSM encodings and the beat record that travels through the FIFO.
package lane_result_streamer_pkg;

  localparam int DEF_OUT_WIDTH  = 64;
  localparam int DEF_OUT_HEIGHT = 32;
  localparam int NUM_LANES      = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_REARM  = 2'd2;

  typedef struct packed {
    logic                 tuser;
    logic                 tlast;
    logic [NUM_LANES-1:0] data;
  } beat_t;

endpackage

// File: rtl/lane_result_streamer_fifo.sv
// Tiny first-word-fall-through FIFO; the head entry is presented on rd_data
// whenever the FIFO is not empty.
module sync_small_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign count   = count_reg;
  assign rd_data = mem_reg[rd_ptr_reg];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= wr_data;
        wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/lane_result_streamer.sv
// Streams one finished lane-mask frame from the result BRAM onto an AXI4-Stream
// master in raster order, once per rising frame-valid level, under backpressure.
module lane_result_streamer
  import lane_result_streamer_pkg::*;
#(
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int OUT_HEIGHT = DEF_OUT_HEIGHT,
  parameter int RD_LATENCY = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    i_frame_valid,
  output logic                                    bram_rd_en,
  output logic [$clog2(OUT_WIDTH*OUT_HEIGHT)-1:0] bram_rd_addr,
  input  logic [NUM_LANES-1:0]                    bram_rd_data,
  output logic [NUM_LANES-1:0]                    m_axis_tdata,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic                                    m_axis_tuser,
  output logic                                    m_axis_tlast,
  output logic                                    frame_done,
  output logic                                    busy
);

  localparam int N          = OUT_WIDTH * OUT_HEIGHT;
  localparam int AW         = $clog2(N);
  localparam int CW         = AW + 1;
  localparam int COLW       = $clog2(OUT_WIDTH);
  localparam int FIFO_DEPTH = RD_LATENCY + 1;
  localparam int FCW        = $clog2(FIFO_DEPTH + 1);

  logic [1:0]      state_reg;
  logic [CW-1:0]   rd_addr_reg;
  logic [CW-1:0]   out_cnt_reg;
  logic [COLW-1:0] col_reg;
  logic            frame_done_reg;
  logic            vld_sr_reg  [RD_LATENCY];
  logic [1:0]      meta_sr_reg [RD_LATENCY];

  logic            streaming;
  logic            pop;
  logic            last_col;
  logic            last_pixel;
  logic [FCW:0]    inflight;
  logic [FCW:0]    occupancy;
  logic [FCW-1:0]  fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  beat_t           fifo_wr;
  beat_t           fifo_rd;

  assign streaming  = (state_reg == ST_STREAM);
  assign pop        = m_axis_tvalid && m_axis_tready;
  assign last_col   = (col_reg == COLW'(OUT_WIDTH - 1));
  assign last_pixel = (out_cnt_reg == CW'(N - 1));

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + (FCW+1)'(vld_sr_reg[i]);
  end

  // A beat leaving this cycle frees its slot, which keeps one issue per cycle
  // sustainable with tready held high.
  assign occupancy  = (FCW+1)'(fifo_count) + inflight - (FCW+1)'(pop);
  assign bram_rd_en = streaming && (rd_addr_reg < CW'(N)) && (occupancy < (FCW+1)'(FIFO_DEPTH));
  assign bram_rd_addr = rd_addr_reg[AW-1:0];

  for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_rd_pipe
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_sr_reg[gi]  <= 1'b0;
          meta_sr_reg[gi] <= '0;
        end else begin
          vld_sr_reg[gi]  <= bram_rd_en;
          meta_sr_reg[gi] <= {(rd_addr_reg == '0), last_col};
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_sr_reg[gi]  <= 1'b0;
          meta_sr_reg[gi] <= '0;
        end else begin
          vld_sr_reg[gi]  <= vld_sr_reg[gi-1];
          meta_sr_reg[gi] <= meta_sr_reg[gi-1];
        end
      end
    end
  end

  assign fifo_wr = '{tuser: meta_sr_reg[RD_LATENCY-1][1],
                     tlast: meta_sr_reg[RD_LATENCY-1][0],
                     data:  bram_rd_data};

  sync_small_fifo #(
    .WIDTH($bits(beat_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (vld_sr_reg[RD_LATENCY-1]),
    .wr_data (fifo_wr),
    .pop     (pop),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(vld_sr_reg[RD_LATENCY-1] && fifo_full && !pop));

  // Exit is keyed on delivered beats, since the last read is issued while
  // earlier pixels are still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      rd_addr_reg    <= '0;
      col_reg        <= '0;
      out_cnt_reg    <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          rd_addr_reg <= '0;
          col_reg     <= '0;
          out_cnt_reg <= '0;
          if (i_frame_valid) state_reg <= ST_STREAM;
        end
        ST_STREAM: begin
          if (bram_rd_en) begin
            rd_addr_reg <= rd_addr_reg + CW'(1);
            col_reg     <= last_col ? '0 : col_reg + COLW'(1);
          end
          if (pop) begin
            out_cnt_reg <= out_cnt_reg + CW'(1);
            if (last_pixel) begin
              frame_done_reg <= 1'b1;
              state_reg      <= ST_REARM;
            end
          end
        end
        ST_REARM: if (!i_frame_valid) state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_rd.data;
  assign m_axis_tuser  = fifo_rd.tuser;
  assign m_axis_tlast  = fifo_rd.tlast;
  assign frame_done    = frame_done_reg;
  assign busy          = streaming;

endmodule
